seq_alu: RTL and testbench

Parametrised multi-cycle ALU and the next generation of the single-cycle 8-bit datapath ALU.
- Generalises width to WIDTH bits.
- Implements the two reserved opcodes: unsigned multiply (110) and unsigned divide (111), as iterative shift-add and restoring-divide units.
- Start/ready/valid handshake so the single-cycle core's control can stall on long ops.
- Sits between the register-file read ports and the writeback mux.

---
 rtl/seq_alu.sv | 117 +++++++++++
 tb/tb_seq_alu.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: parametrised multi-cycle ALU with iterative multiply/divide and start/ready/valid handshake
module seq_alu #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       fn_select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             cout,
  output logic             flag_eq,
  output logic             flag_overflow,
  output logic             flag_divzero
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_b, acc, sh, rem, bb, logic_r, dsub;
  logic [WIDTH:0] sum, mac, dsh;
  logic sub, c_msb, ge, last, eq_r, arith;
  always_comb begin
    sub = fn_select == 3'b001;
    arith = fn_select[2:1] == 2'b00;
    bb = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    c_msb = a[WIDTH-1] ^ bb[WIDTH-1] ^ sum[WIDTH-1];
    logic_r = fn_select == 3'b010 ? a & b :
              fn_select == 3'b011 ? ~a :
              fn_select == 3'b100 ? a | b : a ^ b;
    // multiplier LSB sits in sh[0]; carry out of the add lands in mac[WIDTH]
    mac = {1'b0, acc} + {1'b0, sh[0] ? op_b : {WIDTH{1'b0}}};
    dsh = {rem, sh[WIDTH-1]};
    ge = dsh >= {1'b0, op_b};
    dsub = ge ? WIDTH'(dsh - {1'b0, op_b}) : dsh[WIDTH-1:0];
    last = cnt == CNT_W'(WIDTH - 1);
  end
  assign ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      valid <= 1'b0;
      res <= '0;
      res_hi <= '0;
      cout <= 1'b0;
      flag_eq <= 1'b0;
      flag_overflow <= 1'b0;
      flag_divzero <= 1'b0;
      op_b <= '0;
      acc <= '0;
      sh <= '0;
      rem <= '0;
      eq_r <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          eq_r <= a == b;
          cnt <= '0;
          acc <= '0;
          rem <= '0;
          op_b <= fn_select == 3'b110 ? a : b;
          sh <= fn_select == 3'b110 ? b : a;
          if (fn_select == 3'b110) state <= MUL;
          else if (fn_select == 3'b111 && b != '0) state <= DIV;
          else begin
            state <= DONE;
            valid <= 1'b1;
            flag_eq <= a == b;
            res <= arith ? sum[WIDTH-1:0] : fn_select == 3'b111 ? '1 : logic_r;
            res_hi <= fn_select == 3'b111 ? a : '0;
            cout <= arith & sum[WIDTH];
            flag_overflow <= arith & (c_msb ^ sum[WIDTH]);
            flag_divzero <= fn_select == 3'b111;
          end
        end
        MUL: begin
          acc <= mac[WIDTH:1];
          sh <= {mac[0], sh[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            valid <= 1'b1;
            res <= {mac[0], sh[WIDTH-1:1]};
            res_hi <= mac[WIDTH:1];
            cout <= 1'b0;
            flag_eq <= eq_r;
            flag_overflow <= |mac[WIDTH:1];
            flag_divzero <= 1'b0;
          end
        end
        DIV: begin
          rem <= dsub;
          sh <= {sh[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            valid <= 1'b1;
            res <= {sh[WIDTH-2:0], ge};
            res_hi <= dsub;
            cout <= 1'b0;
            flag_eq <= eq_r;
            flag_overflow <= 1'b0;
            flag_divzero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu with directed vectors and a decoupled monitor
module tb_seq_alu;
  logic clk = 0, rst = 1, start = 0;
  logic [2:0] fn_select = 0;
  logic [7:0] a = 0, b = 0;
  logic ready, valid, cout, flag_eq, flag_overflow, flag_divzero;
  logic [7:0] res, res_hi;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    int tag;
    logic [7:0] r, h;
    logic c, e, o, z;
    int due;
  } exp_t;
  exp_t q[$];
  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .fn_select(fn_select), .a(a), .b(b),
    .ready(ready), .valid(valid), .res(res), .res_hi(res_hi), .cout(cout),
    .flag_eq(flag_eq), .flag_overflow(flag_overflow), .flag_divzero(flag_divzero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid cyc=%0d res=%h res_hi=%h", cyc, res, res_hi);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({res, res_hi, cout, flag_eq, flag_overflow, flag_divzero} !== {e.r, e.h, e.c, e.e, e.o, e.z} || cyc != e.due) begin
          bad++;
          $display("FAIL op%0d got res=%h hi=%h c=%b eq=%b ov=%b dz=%b cyc=%0d want res=%h hi=%h c=%b eq=%b ov=%b dz=%b cyc=%0d",
                   e.tag, res, res_hi, cout, flag_eq, flag_overflow, flag_divzero, cyc,
                   e.r, e.h, e.c, e.e, e.o, e.z, e.due);
        end
      end
    end
  end
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask
  task automatic issue(int tag, logic [2:0] f, logic [7:0] x, logic [7:0] y, logic [7:0] r, logic [7:0] h,
                       logic c, logic e, logic o, logic z, int lat, bit push = 1);
    @(negedge clk);
    wait_ready();
    start = 1; fn_select = f; a = x; b = y;
    if (push) q.push_back('{tag, r, h, c, e, o, z, cyc + lat});
    @(negedge clk);
    start = 0; fn_select = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask
  initial begin
    int n, lowc, k;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 1);
    check("rst_valid", {31'b0, valid}, 0);
    rst = 0;
    @(negedge clk);
    check("rst_outs", {res, res_hi, 4'b0, cout, flag_eq, flag_overflow, flag_divzero}, 0);
    issue(1, 3'b000, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1, 0, 1);
    issue(2, 3'b001, 8'h05, 8'h05, 8'h00, 8'h00, 1, 1, 0, 0, 1);
    issue(3, 3'b001, 8'h03, 8'h05, 8'hFE, 8'h00, 0, 0, 0, 0, 1);
    issue(4, 3'b010, 8'hA5, 8'h3C, 8'h24, 8'h00, 0, 0, 0, 0, 1);
    issue(5, 3'b011, 8'hA5, 8'h3C, 8'h5A, 8'h00, 0, 0, 0, 0, 1);
    issue(6, 3'b100, 8'h5A, 8'h5A, 8'h5A, 8'h00, 0, 1, 0, 0, 1);
    issue(7, 3'b000, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0, 1);
    issue(8, 3'b110, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 1, 1, 0, 9);
    lowc = 0;
    for (int i = 0; i < 9; i++) begin
      if (!ready) lowc++;
      @(negedge clk);
    end
    check("mul_busy_cycles", lowc, 9);
    check("mul_ready_after", {31'b0, ready}, 1);
    issue(9, 3'b110, 8'h0F, 8'h11, 8'hFF, 8'h00, 0, 0, 0, 0, 9);
    issue(10, 3'b111, 8'd200, 8'd7, 8'h1C, 8'h04, 0, 0, 0, 0, 9);
    issue(11, 3'b111, 8'h2A, 8'h00, 8'hFF, 8'h2A, 0, 0, 0, 1, 1);
    issue(12, 3'b111, 8'h09, 8'h09, 8'h01, 8'h00, 0, 1, 0, 0, 9);
    // start held high through a whole mul with changing operands
    @(negedge clk);
    wait_ready();
    start = 1; fn_select = 3'b110; a = 8'h0D; b = 8'h0B;
    n = cyc;
    q.push_back('{13, 8'h8F, 8'h00, 0, 0, 0, 0, n + 9});
    @(negedge clk);
    fn_select = 3'b000; a = 8'h03; b = 8'h05;
    k = 0;
    while (!ready && k < 30) begin
      @(negedge clk);
      a = a + 8'h00;
      k++;
    end
    check("spam_next_accept_cyc", cyc, n + 10);
    q.push_back('{14, 8'h08, 8'h00, 0, 0, 0, 0, cyc + 1});
    @(negedge clk);
    start = 0;
    // reset in the middle of a mul
    issue(15, 3'b110, 8'h12, 8'h34, 8'h00, 8'h00, 0, 0, 0, 0, 9, 0);
    n = cyc - 1;
    while (cyc < n + 4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_ready", {31'b0, ready}, 1);
    check("abort_outs", {valid, res, res_hi, cout, flag_eq, flag_overflow, flag_divzero}, 0);
    repeat (10) @(negedge clk);
    issue(16, 3'b101, 8'hF0, 8'h3C, 8'hCC, 8'h00, 0, 0, 0, 0, 1);
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
